// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller for the microcoded FPU: accepts one op, strobes start, waits for busy low, presents the result.
// Latency: accept -> start strobe +1 cycle -> result valid no earlier than +3 cycles; watchdog forces completion after TIMEOUT wait cycles.
// Backpressure: issueReady_o only in IDLE; the result is held in DONE until wbReady_i or a flush.
module fpu_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        issueValid_i,
    output logic        issueReady_o,
    input  logic [29:0] instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rs3_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        fpuEnable_o,
    output logic [29:0] fpuInstr_o,
    output logic [31:0] fpuRs1_o,
    output logic [31:0] fpuRs2_o,
    output logic [31:0] fpuRs3_o,
    input  logic        fpuBusy_i,
    input  logic [31:0] fpuOut_i,
    output logic        wbValid_o,
    input  logic        wbReady_i,
    output logic [4:0]  wbRd_o,
    output logic [31:0] wbData_o,
    output logic        timeout_o,
    output logic [31:0] opCount_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      CANON_NAN = 32'h7FC0_0000;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             discard;
    logic             accept;
    logic             wait_done;
    logic             wait_tmo;
    logic             drop;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        issueReady_o = 1'b0;
        fpuEnable_o  = 1'b0;
        wbValid_o    = 1'b0;
        accept       = 1'b0;
        wait_done    = 1'b0;
        wait_tmo     = 1'b0;
        // A flush in the exit cycle discards just like an earlier one.
        drop         = discard | flush_i;
        case (state)
            IDLE: begin
                issueReady_o = 1'b1;
                if (issueValid_i && !flush_i) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                fpuEnable_o = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (!fpuBusy_i) begin
                    wait_done = 1'b1;
                    state_nxt = drop ? IDLE : DONE;
                end else if (wd_cnt == CNT_LAST) begin
                    wait_tmo  = 1'b1;
                    state_nxt = drop ? IDLE : DONE;
                end
            end
            DONE: begin
                wbValid_o = 1'b1;
                if (flush_i || wbReady_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fpuInstr_o <= '0;
            fpuRs1_o   <= '0;
            fpuRs2_o   <= '0;
            fpuRs3_o   <= '0;
            wbRd_o     <= '0;
            wbData_o   <= '0;
            timeout_o  <= 1'b0;
            opCount_o  <= '0;
            discard    <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            if (accept) begin
                fpuInstr_o <= instr_i;
                fpuRs1_o   <= rs1_i;
                fpuRs2_o   <= rs2_i;
                fpuRs3_o   <= rs3_i;
                wbRd_o     <= rd_i;
                discard    <= 1'b0;
            end

            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            // The FPU is never aborted; a flush only marks the result for dropping.
            if ((state == ISSUE || state == WAIT) && flush_i) begin
                discard <= 1'b1;
            end

            if (wait_done) begin
                wbData_o <= fpuOut_i;
            end
            if (wait_tmo) begin
                timeout_o <= 1'b1;
                wbData_o  <= CANON_NAN;
            end

            // Counted on entry to DONE; a flush in DONE takes the count back.
            if ((wait_done || wait_tmo) && !drop) begin
                opCount_o <= opCount_o + 32'd1;
            end else if (state == DONE && flush_i) begin
                opCount_o <= opCount_o - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: table of single ops plus hand sequences for backpressure, flush, reset and watchdog.
module tb_fpu_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issueValid_i;
    logic        issueReady_o;
    logic [29:0] instr_i;
    logic [31:0] rs1_i, rs2_i, rs3_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        fpuEnable_o;
    logic [29:0] fpuInstr_o;
    logic [31:0] fpuRs1_o, fpuRs2_o, fpuRs3_o;
    logic        fpuBusy_i;
    logic [31:0] fpuOut_i;
    logic        wbValid_o;
    logic        wbReady_i;
    logic [4:0]  wbRd_o;
    logic [31:0] wbData_o;
    logic        timeout_o;
    logic [31:0] opCount_o;

    fpu_issue_ctrl #(.TIMEOUT(64)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .issueValid_i(issueValid_i), .issueReady_o(issueReady_o),
        .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .rd_i(rd_i),
        .flush_i(flush_i), .fpuEnable_o(fpuEnable_o), .fpuInstr_o(fpuInstr_o),
        .fpuRs1_o(fpuRs1_o), .fpuRs2_o(fpuRs2_o), .fpuRs3_o(fpuRs3_o),
        .fpuBusy_i(fpuBusy_i), .fpuOut_i(fpuOut_i),
        .wbValid_o(wbValid_o), .wbReady_i(wbReady_i), .wbRd_o(wbRd_o), .wbData_o(wbData_o),
        .timeout_o(timeout_o), .opCount_o(opCount_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [29:0] instr;
        logic [31:0] rs1, rs2, rs3;
        logic [4:0]  rd;
        int          busy_len;
        logic [31:0] fpu_out;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    // FPU model: busy rises with the start strobe and stays high for busy_len wait cycles.
    int busy_len = 0;
    int rem = 0;
    initial fpuBusy_i = 1'b0;
    always @(negedge clk_i) begin
        if (fpuEnable_o) begin
            rem = busy_len;
            fpuBusy_i = (busy_len > 0);
        end else begin
            fpuBusy_i = (rem > 0);
            if (rem > 0) rem = rem - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input vec_t v);
        issueValid_i = 1'b1;
        instr_i = v.instr;
        rs1_i = v.rs1;
        rs2_i = v.rs2;
        rs3_i = v.rs3;
        rd_i = v.rd;
        busy_len = v.busy_len;
        fpuOut_i = v.fpu_out;
    endtask

    // Accept edge, then scramble inputs so only registered copies can be correct.
    task automatic issue(input vec_t v);
        drive(v);
        tick();
        issueValid_i = 1'b0;
        instr_i = ~v.instr;
        rs1_i = ~v.rs1;
        rs2_i = ~v.rs2;
        rs3_i = ~v.rs3;
        rd_i = ~v.rd;
    endtask

    // Returns the cycle (1 = cycle after accept) in which wbValid_o first appears.
    task automatic wait_wb(output int lat, output int en, output int rdy_bad);
        lat = 1;
        en = 0;
        rdy_bad = 0;
        while (!wbValid_o && lat < 200) begin
            if (fpuEnable_o) en++;
            if (issueReady_o) rdy_bad++;
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        wbReady_i = 1'b1;
        tick();
        wbReady_i = 1'b0;
        check("wb_valid_after_hs", {31'd0, wbValid_o}, 32'd0);
        check("ready_after_hs", {31'd0, issueReady_o}, 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int lat, en, rdy_bad;
        check("ready_idle", {31'd0, issueReady_o}, 32'd1);
        issue(v);
        wait_wb(lat, en, rdy_bad);
        exp_cnt++;
        check("latency", lat, v.exp_lat);
        check("enable_pulses", en, 1);
        check("ready_low_busy", rdy_bad, 0);
        check("wb_data", wbData_o, v.exp_data);
        check("wb_rd", {27'd0, wbRd_o}, {27'd0, v.rd});
        check("fpu_instr", {2'd0, fpuInstr_o}, {2'd0, v.instr});
        check("fpu_rs1", fpuRs1_o, v.rs1);
        check("fpu_rs2", fpuRs2_o, v.rs2);
        check("fpu_rs3", fpuRs3_o, v.rs3);
        check("op_count", opCount_o, exp_cnt);
        check("no_timeout", {31'd0, timeout_o}, 32'd0);
        handshake();
    endtask

    vec_t vecs[5];
    vec_t va, vb, vs;
    int lat, en, rdy_bad, bad;

    initial begin
        //           instr          rs1           rs2           rs3           rd     busy out           lat exp_data
        vecs[0] = '{30'h0008_2074, 32'h3F800000, 32'h40000000, 32'h00000000, 5'd3,  4,  32'h40400000, 7,  32'h40400000}; // FADD
        vecs[1] = '{30'h0808_2074, 32'h3F800000, 32'hBF800000, 32'h00000000, 5'd7,  0,  32'hBF800000, 3,  32'hBF800000}; // FSGNJ
        vecs[2] = '{30'h0408_2074, 32'h40000000, 32'h40400000, 32'h12345678, 5'd31, 1,  32'h40C00000, 4,  32'h40C00000}; // FMUL
        vecs[3] = '{30'h0608_2074, 32'h41200000, 32'h40000000, 32'hA5A5A5A5, 5'd1,  10, 32'h40A00000, 13, 32'h40A00000}; // FDIV
        vecs[4] = '{30'h1608_2074, 32'h40800000, 32'h00000000, 32'hFFFFFFFF, 5'd9,  63, 32'h40000000, 66, 32'h40000000}; // busy ends on last watchdog cycle

        reset_i = 1'b0;
        issueValid_i = 1'b0;
        instr_i = '0; rs1_i = '0; rs2_i = '0; rs3_i = '0; rd_i = '0;
        flush_i = 1'b0;
        fpuOut_i = '0;
        wbReady_i = 1'b0;
        repeat (3) tick();
        check("rst_ready", {31'd0, issueReady_o}, 32'd1);
        check("rst_enable", {31'd0, fpuEnable_o}, 32'd0);
        check("rst_wbvalid", {31'd0, wbValid_o}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("rst_opcount", opCount_o, 32'd0);
        check("rst_wbdata", wbData_o, 32'd0);
        reset_i = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_op(vecs[i]);

        // Flush in IDLE blocks acceptance.
        drive(vecs[0]);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        issueValid_i = 1'b0;
        check("idle_flush_no_issue", {31'd0, fpuEnable_o}, 32'd0);
        check("idle_flush_ready", {31'd0, issueReady_o}, 32'd1);

        // Writeback backpressure with a second op waiting.
        va = vecs[1];
        vb = vecs[2];
        issue(va);
        wait_wb(lat, en, rdy_bad);
        exp_cnt++;
        check("bp_latency", lat, 3);
        drive(vb);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (wbValid_o !== 1'b1 || wbRd_o !== va.rd || wbData_o !== va.exp_data
                || issueReady_o !== 1'b0 || fpuInstr_o !== va.instr) bad++;
            tick();
        end
        check("bp_hold_stable", bad, 0);
        wbReady_i = 1'b1;
        tick();
        wbReady_i = 1'b0;
        check("bp_idle_valid", {31'd0, wbValid_o}, 32'd0);
        check("bp_instr_kept", {2'd0, fpuInstr_o}, {2'd0, va.instr});
        tick();
        issueValid_i = 1'b0;
        check("bp_second_enable", {31'd0, fpuEnable_o}, 32'd1);
        check("bp_second_instr", {2'd0, fpuInstr_o}, {2'd0, vb.instr});
        wait_wb(lat, en, rdy_bad);
        exp_cnt++;
        check("bp_second_data", wbData_o, vb.exp_data);
        check("bp_second_count", opCount_o, exp_cnt);
        handshake();

        // Flush in the 2nd WAIT cycle; busy drops 3 cycles later.
        vs = vecs[0];
        issue(vs);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (wbValid_o) bad++;
            tick();
        end
        check("flush_no_wb", bad, 0);
        check("flush_idle", {31'd0, issueReady_o}, 32'd1);
        check("flush_count", opCount_o, exp_cnt);
        run_op(vecs[3]);

        // Flush in DONE together with wbReady_i: result dropped, count restored.
        issue(vecs[1]);
        wait_wb(lat, en, rdy_bad);
        check("done_count_pre", opCount_o, exp_cnt + 1);
        flush_i = 1'b1;
        wbReady_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wbReady_i = 1'b0;
        check("done_flush_valid", {31'd0, wbValid_o}, 32'd0);
        check("done_flush_count", opCount_o, exp_cnt);
        check("done_flush_ready", {31'd0, issueReady_o}, 32'd1);

        // Reset during WAIT abandons the op.
        issue(vecs[3]);
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        exp_cnt = 0;
        check("mid_rst_ready", {31'd0, issueReady_o}, 32'd1);
        check("mid_rst_enable", {31'd0, fpuEnable_o}, 32'd0);
        check("mid_rst_valid", {31'd0, wbValid_o}, 32'd0);
        check("mid_rst_instr", {2'd0, fpuInstr_o}, 32'd0);
        check("mid_rst_rs", fpuRs1_o | fpuRs2_o | fpuRs3_o, 32'd0);
        check("mid_rst_wb", {27'd0, wbRd_o} | wbData_o, 32'd0);
        check("mid_rst_count", opCount_o, 32'd0);
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            if (fpuEnable_o || wbValid_o) bad++;
            tick();
        end
        check("mid_rst_quiet", bad, 0);

        // Busy stuck high: watchdog fires after 64 WAIT cycles.
        vs = vecs[3];
        vs.busy_len = 1000;
        issue(vs);
        wait_wb(lat, en, rdy_bad);
        check("tmo_latency", lat, 66);
        check("tmo_flag", {31'd0, timeout_o}, 32'd1);
        check("tmo_data", wbData_o, 32'h7FC00000);
        check("tmo_valid", {31'd0, wbValid_o}, 32'd1);
        handshake();
        tick();
        check("tmo_sticky", {31'd0, timeout_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
